key_schedule_ctrl: RTL and testbench

Sequencer for the combinational key_expansion datapath. It takes a 128-bit cipher key and drives the shared key_expansion instance once per cycle for NUM_ROUNDS rounds. Each resulting round key is captured into an internal round-key file. The AES round engine reads round keys from this file by index once keys_valid is high.

---
 rtl/key_schedule_ctrl.sv | 130 +++++++++++++
 tb/tb_key_schedule_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_schedule_ctrl.sv
// Drives one shared combinational key_expansion for NUM_ROUNDS cycles and stores each round key.
// done pulses NUM_ROUNDS+1 cycles after start is accepted; start outside IDLE is dropped, never queued.
module key_schedule_ctrl #(
  parameter int regSize    = 32,
  parameter int vecSize    = 4,
  parameter int NUM_ROUNDS = 10
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic                             clear,
  input  logic [vecSize-1:0][regSize-1:0]  key_in,
  output logic                             busy,
  output logic                             done,
  output logic                             keys_valid,
  output logic [vecSize-1:0][regSize-1:0]  exp_cur_key,
  output logic [3:0]                       exp_round,
  input  logic [vecSize-1:0][regSize-1:0]  exp_next_key,
  input  logic [3:0]                       rd_idx,
  output logic [vecSize-1:0][regSize-1:0]  rd_key
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXPAND,
    S_DONE
  } state_t;

  typedef logic [vecSize-1:0][regSize-1:0] rkey_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       kv_q, kv_d;
  rkey_t      rk_q [0:NUM_ROUNDS];

  logic       wr_en;
  logic [3:0] wr_idx;
  rkey_t      wr_dat;
  logic [3:0] prev_idx;

  assign prev_idx = cnt_q - 4'd1;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    kv_d        = kv_q;
    wr_en       = 1'b0;
    wr_idx      = '0;
    wr_dat      = exp_next_key;
    busy        = 1'b0;
    done        = 1'b0;
    exp_cur_key = '0;
    exp_round   = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          wr_en   = 1'b1;
          wr_idx  = '0;
          wr_dat  = key_in;
          cnt_d   = 4'd1;
          kv_d    = 1'b0;
          state_d = S_EXPAND;
        end
      end
      S_EXPAND: begin
        busy        = 1'b1;
        exp_cur_key = rk_q[prev_idx];
        exp_round   = cnt_q;
        wr_en       = 1'b1;
        wr_idx      = cnt_q;
        if (cnt_q == 4'(NUM_ROUNDS)) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        kv_d    = 1'b1;
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Flush overrides everything, including a same-cycle start; stored keys stay put.
    if (clear) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      kv_d    = 1'b0;
      wr_en   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      kv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      kv_q    <= kv_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= NUM_ROUNDS; i++) begin
        rk_q[i] <= '0;
      end
    end else if (wr_en) begin
      rk_q[wr_idx] <= wr_dat;
    end
  end

  assign keys_valid = kv_q;

  always_comb begin
    rd_key = '0;
    if (rd_idx <= 4'(NUM_ROUNDS)) begin
      rd_key = rk_q[rd_idx];
    end
  end

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Bench for key_schedule_ctrl with an AES-128 key_expansion step attached to its datapath ports.
module tb_key_schedule_ctrl;

  localparam int NR = 10;

  typedef logic [3:0][31:0] key_t;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       clear;
  key_t       key_in;
  logic       busy;
  logic       done;
  logic       keys_valid;
  key_t       exp_cur_key;
  logic [3:0] exp_round;
  key_t       exp_next_key;
  logic [3:0] rd_idx;
  key_t       rd_key;

  int n_checks = 0;
  int n_fail   = 0;

  key_schedule_ctrl #(.regSize(32), .vecSize(4), .NUM_ROUNDS(NR)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .clear        (clear),
    .key_in       (key_in),
    .busy         (busy),
    .done         (done),
    .keys_valid   (keys_valid),
    .exp_cur_key  (exp_cur_key),
    .exp_round    (exp_round),
    .exp_next_key (exp_next_key),
    .rd_idx       (rd_idx),
    .rd_key       (rd_key)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, required completion");
    $fatal(1);
  end

  // ---------------- AES arithmetic ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sub_byte(input logic [7:0] x);
    logic [7:0] v;
    v = 8'h00;
    for (int y = 1; y < 256; y++) begin
      if (gmul(x, 8'(y)) == 8'h01) v = 8'(y);
    end
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sub_byte(w[31:24]), sub_byte(w[23:16]), sub_byte(w[15:8]), sub_byte(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input int r);
    logic [7:0] c;
    c = 8'h01;
    for (int i = 1; i < r; i++) c = {c[6:0], 1'b0} ^ (c[7] ? 8'h1b : 8'h00);
    return c;
  endfunction

  // One round of the external key_expansion datapath.
  function automatic key_t exp_step(input key_t k, input logic [3:0] rnd);
    key_t n;
    logic [31:0] t;
    t = sub_word({k[3][23:0], k[3][31:24]}) ^ {rcon(int'(rnd)), 24'h0};
    n[0] = k[0] ^ t;
    n[1] = k[1] ^ n[0];
    n[2] = k[2] ^ n[1];
    n[3] = k[3] ^ n[2];
    return n;
  endfunction

  assign exp_next_key = exp_step(exp_cur_key, exp_round);

  function automatic key_t mk_key(input logic [31:0] w0, input logic [31:0] w1,
                                  input logic [31:0] w2, input logic [31:0] w3);
    key_t k;
    k[0] = w0; k[1] = w1; k[2] = w2; k[3] = w3;
    return k;
  endfunction

  // ---------------- reference model ----------------
  // m_t: 0 idle, 1..NR expansion round, NR+1 the done cycle.
  int   m_t;
  logic m_kv;
  key_t m_file  [0:NR];
  key_t m_sched [0:NR];

  task automatic compute_sched(input key_t k);
    logic [31:0] w [0:4*NR+3];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = k[i];
    for (int i = 4; i < 4*NR+4; i++) begin
      t = w[i-1];
      if (i % 4 == 0) t = sub_word({t[23:0], t[31:24]}) ^ {rcon(i/4), 24'h0};
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= NR; r++)
      for (int j = 0; j < 4; j++) m_sched[r][j] = w[4*r+j];
  endtask

  task automatic model_reset();
    m_t  = 0;
    m_kv = 1'b0;
    for (int i = 0; i <= NR; i++) m_file[i] = '0;
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      model_reset();
    end else if (clear) begin
      m_t  = 0;
      m_kv = 1'b0;
    end else if (m_t == 0) begin
      if (start) begin
        m_file[0] = key_in;
        compute_sched(key_in);
        m_t  = 1;
        m_kv = 1'b0;
      end
    end else if (m_t <= NR) begin
      m_file[m_t] = m_sched[m_t];
      m_t = m_t + 1;
    end else begin
      m_kv = 1'b1;
      m_t  = 0;
    end
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_all();
    logic m_busy;
    key_t exp_rd;
    m_busy = (m_t >= 1 && m_t <= NR);
    chk("busy", busy, m_busy);
    chk("done", done, m_t == NR + 1);
    chk("keys_valid", keys_valid, m_kv);
    chk("exp_round", exp_round, m_busy ? m_t : 0);
    chk("exp_cur_key", exp_cur_key, m_busy ? m_file[m_t-1] : key_t'(0));
    exp_rd = '0;
    if (int'(rd_idx) <= NR) exp_rd = m_file[rd_idx];
    chk("rd_key", rd_key, exp_rd);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic run_expansion(input key_t k);
    int n;
    key_in = k;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    key_in = mk_key($urandom, $urandom, $urandom, $urandom);
    n = 1;
    while (!done && n < 30) begin
      tick();
      n++;
    end
    chk("done_latency", n, 11);
    tick();
    chk("keys_valid_after_done", keys_valid, 1'b1);
  endtask

  task automatic wait_round(input logic [3:0] r);
    int n;
    n = 0;
    while (exp_round != r && n < 20) begin
      tick();
      n++;
    end
    chk("reach_round", exp_round, r);
  endtask

  typedef struct {
    key_t       key;
    logic [3:0] idx;
    key_t       exp;
  } vec_t;

  vec_t tab [9];

  initial begin
    key_t k0, k1;
    int   ndone;
    int   pos [$];

    k0 = '0;
    k1 = mk_key(32'h2b7e1516, 32'h28aed2a6, 32'habf71588, 32'h09cf4f3c);
    tab[0] = '{k0, 4'd1,  mk_key(32'h62636363, 32'h62636363, 32'h62636363, 32'h62636363)};
    tab[1] = '{k0, 4'd10, mk_key(32'hb4ef5bcb, 32'h3e92e211, 32'h23e951cf, 32'h6f8f188e)};
    tab[2] = '{k1, 4'd0,  k1};
    tab[3] = '{k1, 4'd1,  mk_key(32'ha0fafe17, 32'h88542cb1, 32'h23a33939, 32'h2a6c7605)};
    tab[4] = '{k1, 4'd10, mk_key(32'hd014f9a8, 32'hc9ee2589, 32'he13f0cc8, 32'hb6630ca6)};
    tab[5] = '{k1, 4'd11, key_t'(0)};
    tab[6] = '{k1, 4'd12, key_t'(0)};
    tab[7] = '{k1, 4'd13, key_t'(0)};
    tab[8] = '{k1, 4'd15, key_t'(0)};

    rst_n = 1'b0; start = 1'b0; clear = 1'b0; key_in = '0; rd_idx = '0;
    model_reset();
    tick();
    check_all();
    for (int i = 0; i < 16; i++) begin
      rd_idx = 4'(i);
      #1;
      chk("reset_rd_key", rd_key, 0);
    end
    rst_n = 1'b1;
    tick();

    // Known-answer vectors.
    for (int i = 0; i < 9; i++) begin
      if (i == 0 || tab[i].key !== tab[i-1].key) run_expansion(tab[i].key);
      rd_idx = tab[i].idx;
      #1;
      chk("table_rd_key", rd_key, tab[i].exp);
      chk("table_keys_valid", keys_valid, 1'b1);
    end

    // start held for 20 edges: accepted at edge 1 and edge 13 only.
    key_in = mk_key($urandom, $urandom, $urandom, $urandom);
    start  = 1'b1;
    for (int c = 1; c <= 36; c++) begin
      if (c == 21) start = 1'b0;
      rd_idx = 4'($urandom_range(15));
      tick();
      if (done) pos.push_back(c);
    end
    chk("held_start_done_count", pos.size(), 2);
    if (pos.size() == 2) begin
      chk("held_start_done1_pos", pos[0], 11);
      chk("held_start_done2_pos", pos[1], 23);
    end

    // clear at round 4, then a normal expansion.
    key_in = mk_key($urandom, $urandom, $urandom, $urandom);
    start  = 1'b1;
    tick();
    start  = 1'b0;
    wait_round(4'd4);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clear_busy", busy, 1'b0);
    chk("clear_keys_valid", keys_valid, 1'b0);
    ndone = 0;
    for (int c = 0; c < 14; c++) begin
      tick();
      if (done) ndone++;
    end
    chk("clear_no_done", ndone, 0);
    run_expansion(k1);
    rd_idx = 4'd10;
    #1;
    chk("after_clear_rd10", rd_key, tab[4].exp);

    // start and clear together.
    start = 1'b1; clear = 1'b1;
    tick();
    start = 1'b0; clear = 1'b0;
    chk("start_clear_busy", busy, 1'b0);
    chk("start_clear_round", exp_round, 4'd0);
    tick();

    // Asynchronous reset in the middle of an expansion.
    key_in = mk_key($urandom, $urandom, $urandom, $urandom);
    start  = 1'b1;
    tick();
    start  = 1'b0;
    wait_round(4'd5);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("midreset_busy", busy, 1'b0);
    chk("midreset_keys_valid", keys_valid, 1'b0);
    for (int i = 0; i < 16; i++) begin
      rd_idx = 4'(i);
      #1;
      chk("midreset_rd_key", rd_key, 0);
    end
    tick();
    rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (done) ndone++;
    end
    chk("midreset_no_done", ndone, 0);

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      start  = ($urandom_range(3) == 0);
      clear  = ($urandom_range(24) == 0);
      key_in = mk_key($urandom, $urandom, $urandom, $urandom);
      rd_idx = 4'($urandom_range(15));
      tick();
    end
    start = 1'b0; clear = 1'b0;
    for (int c = 0; c < 14; c++) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
